// File: rtl/video_timing_ctrl.sv
// Raster timing generator: leading pixel counters for the renderer and
// delayed hsync/vsync/vde aligned to the renderer's RGB output.
module video_timing_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        active,
  output logic        new_frame,
  output logic        line_start,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic        running,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] fc_q, fc_d;

  logic run;
  logic last_px;
  logic de_raw;
  logic hs_raw;
  logic vs_raw;

  assign run     = (state_q != IDLE);
  assign last_px = (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 11'd1;
        end
        if (last_px) fc_d = fc_q + 16'd1;
        // Stopping is only honoured on the last pixel of a frame.
        if (enable)       state_d = RUN;
        else if (last_px) state_d = IDLE;
        else              state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
    end
  end

  assign de_raw = run && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = run && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw = run && (v_q >= VS_BEG) && (v_q < VS_END);

  logic [LATENCY-1:0] de_dl_q;
  logic [LATENCY-1:0] hs_dl_q;
  logic [LATENCY-1:0] vs_dl_q;

  // Keeps shifting in IDLE so the tail of the last frame drains out.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_dl_q <= '0;
      hs_dl_q <= {LATENCY{~HS_POL}};
      vs_dl_q <= {LATENCY{~VS_POL}};
    end else begin
      de_dl_q[0] <= de_raw;
      hs_dl_q[0] <= hs_raw ? HS_POL : ~HS_POL;
      vs_dl_q[0] <= vs_raw ? VS_POL : ~VS_POL;
      for (int i = 1; i < LATENCY; i++) begin
        de_dl_q[i] <= de_dl_q[i-1];
        hs_dl_q[i] <= hs_dl_q[i-1];
        vs_dl_q[i] <= vs_dl_q[i-1];
      end
    end
  end

  assign hcount     = h_q;
  assign vcount     = v_q;
  assign active     = de_raw;
  assign new_frame  = run && (h_q == '0) && (v_q == '0);
  assign line_start = run && (h_q == '0);
  assign running    = run;
  assign frame_cnt  = fc_q;
  assign vde        = de_dl_q[LATENCY-1];
  assign hsync      = hs_dl_q[LATENCY-1];
  assign vsync      = vs_dl_q[LATENCY-1];

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a reduced 15x8 raster, with a
// positive-polarity and a negative-polarity instance side by side.
module tb_video_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  bit   rst = 1'b1;
  bit   en  = 1'b0;

  logic [10:0] hcount, n_hcount;
  logic [9:0]  vcount, n_vcount;
  logic        active, n_active;
  logic        new_frame, n_new_frame;
  logic        line_start, n_line_start;
  logic        hsync, n_hsync;
  logic        vsync, n_vsync;
  logic        vde, n_vde;
  logic        running, n_running;
  logic [15:0] frame_cnt, n_frame_cnt;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .enable(en),
    .hcount(hcount), .vcount(vcount), .active(active),
    .new_frame(new_frame), .line_start(line_start),
    .hsync(hsync), .vsync(vsync), .vde(vde),
    .running(running), .frame_cnt(frame_cnt)
  );

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LATENCY(LAT)
  ) dut_n (
    .clk(clk), .rst(rst), .enable(en),
    .hcount(n_hcount), .vcount(n_vcount), .active(n_active),
    .new_frame(n_new_frame), .line_start(n_line_start),
    .hsync(n_hsync), .vsync(n_vsync), .vde(n_vde),
    .running(n_running), .frame_cnt(n_frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the raster, kept in raw (asserted=1) form.
  int eh = 0, ev = 0, efc = 0, est = 0;
  bit pde [LAT];
  bit phs [LAT];
  bit pvs [LAT];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit r_de, r_hs, r_vs, last, e_act, e_run, e_nf, e_ls;
    @(posedge clk);
    if (rst) begin
      est = 0; eh = 0; ev = 0; efc = 0;
      for (int i = 0; i < LAT; i++) begin
        pde[i] = 0; phs[i] = 0; pvs[i] = 0;
      end
    end else begin
      r_de = (est != 0) && (eh < HA) && (ev < VA);
      r_hs = (est != 0) && (eh >= HA + HF) && (eh < HA + HF + HS);
      r_vs = (est != 0) && (ev >= VA + VF) && (ev < VA + VF + VS);
      for (int i = LAT - 1; i > 0; i--) begin
        pde[i] = pde[i-1]; phs[i] = phs[i-1]; pvs[i] = pvs[i-1];
      end
      pde[0] = r_de; phs[0] = r_hs; pvs[0] = r_vs;
      last = (eh == HT - 1) && (ev == VT - 1);
      if (est == 0) begin
        if (en) est = 1;
      end else begin
        if (last) efc = (efc + 1) % 65536;
        if (eh == HT - 1) begin
          eh = 0;
          ev = (ev == VT - 1) ? 0 : ev + 1;
        end else begin
          eh++;
        end
        est = en ? 1 : (last ? 0 : 2);
      end
    end
    #1;
    e_run = (est != 0);
    e_act = e_run && (eh < HA) && (ev < VA);
    e_nf  = e_run && (eh == 0) && (ev == 0);
    e_ls  = e_run && (eh == 0);
    chk("hcount", hcount, eh);
    chk("vcount", vcount, ev);
    chk("active", active, e_act);
    chk("new_frame", new_frame, e_nf);
    chk("line_start", line_start, e_ls);
    chk("running", running, e_run);
    chk("frame_cnt", frame_cnt, efc);
    chk("vde", vde, pde[LAT-1]);
    chk("hsync", hsync, phs[LAT-1]);
    chk("vsync", vsync, pvs[LAT-1]);
    chk("n_hcount", n_hcount, eh);
    chk("n_vcount", n_vcount, ev);
    chk("n_active", n_active, e_act);
    chk("n_new_frame", n_new_frame, e_nf);
    chk("n_line_start", n_line_start, e_ls);
    chk("n_running", n_running, e_run);
    chk("n_frame_cnt", n_frame_cnt, efc);
    chk("n_vde", n_vde, pde[LAT-1]);
    chk("n_hsync", n_hsync, !phs[LAT-1]);
    chk("n_vsync", n_vsync, !pvs[LAT-1]);
  endtask

  task automatic wait_pos(input int h, input int v, output int lows);
    int n;
    lows = 0;
    n = 0;
    while (!(eh == h && ev == v) && n < 300) begin
      tick();
      if (!running) lows++;
      n++;
    end
    if (!(eh == h && ev == v)) begin
      checks++;
      errors++;
      $display("FAIL wait_pos timeout h=%0d v=%0d", h, v);
    end
  endtask

  typedef struct {
    bit rst;
    bit en;
    int h;
    int v;
    bit act;
    bit nf;
    bit ls;
    bit run;
    bit de;
  } vec_t;

  vec_t vt [8];

  initial begin
    int lows, fc0, nf_cnt, nf_first, nf_last;
    int de_cnt, hs_cnt, vs_cnt, n;

    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{0, 1, 0, 0, 1, 1, 1, 1, 0};
    vt[3] = '{0, 1, 1, 0, 1, 0, 0, 1, 0};
    vt[4] = '{0, 1, 2, 0, 1, 0, 0, 1, 1};
    vt[5] = '{0, 1, 3, 0, 1, 0, 0, 1, 1};
    vt[6] = '{0, 0, 4, 0, 1, 0, 0, 1, 1};
    vt[7] = '{0, 1, 5, 0, 1, 0, 0, 1, 1};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst;
      en  = vt[i].en;
      tick();
      chk("vec_h", hcount, vt[i].h);
      chk("vec_v", vcount, vt[i].v);
      chk("vec_active", active, vt[i].act);
      chk("vec_new_frame", new_frame, vt[i].nf);
      chk("vec_line_start", line_start, vt[i].ls);
      chk("vec_running", running, vt[i].run);
      chk("vec_vde", vde, vt[i].de);
      chk("vec_hsync", hsync, 0);
    end

    // Two steady frames: pulse period and per-frame sync/vde totals.
    wait_pos(0, 0, lows);
    nf_cnt = 0; nf_first = 0; nf_last = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 1; i <= 2 * HT * VT; i++) begin
      tick();
      if (new_frame) begin
        if (nf_cnt == 0) nf_first = i;
        nf_last = i;
        nf_cnt++;
      end
      if (vde) de_cnt++;
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
    end
    chk("frame_pulses", nf_cnt, 2);
    chk("frame_period", nf_last - nf_first, HT * VT);
    chk("vde_cycles", de_cnt, 2 * HA * VA);
    chk("hsync_cycles", hs_cnt, 2 * HS * VT);
    chk("vsync_cycles", vs_cnt, 2 * VS * HT);

    // Stop requested mid-frame: completes the frame, then idles.
    wait_pos(0, 4, lows);
    en  = 0;
    fc0 = efc;
    n   = 0;
    while (est != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_running", running, 0);
    chk("drain_h", hcount, 0);
    chk("drain_v", vcount, 0);
    chk("drain_frame_cnt", frame_cnt, (fc0 + 1) % 65536);
    chk("drain_new_frame", new_frame, 0);
    tick();
    tick();
    chk("idle_vde", vde, 0);
    chk("idle_hsync", hsync, 0);
    chk("idle_vsync", vsync, 0);
    chk("idle_n_hsync", n_hsync, 1);

    // Stop then resume inside the same frame.
    en = 1;
    tick();
    chk("restart_new_frame", new_frame, 1);
    wait_pos(0, 2, lows);
    en = 0;
    wait_pos(0, 4, n);
    lows += n;
    en = 1;
    wait_pos(0, 0, n);
    lows += n;
    chk("resume_running_lows", lows, 0);
    chk("resume_new_frame", new_frame, 1);
    chk("resume_running", running, 1);

    // Reset in the middle of a frame.
    wait_pos(5, 2, lows);
    rst = 1;
    tick();
    chk("rst_h", hcount, 0);
    chk("rst_v", vcount, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_running", running, 0);
    chk("rst_vde", vde, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_n_hsync", n_hsync, 1);
    chk("rst_n_vsync", n_vsync, 1);
    rst = 0;
    en  = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
